// File: rtl/ahb_req_burst_seq.sv
// Queues whole AHB requests and sequences them into single-beat INCR/WRAP transfers.
// Build option: define AHB_BURST_WRAP_EN to honour req_wrap; otherwise every burst is INCR.
module ahb_req_burst_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_wrap,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LEN_W-1:0]          req_len,
  input  logic [MAX_LEN*DATA_W-1:0] req_data,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic                      beat_write,
  output logic [ADDR_W-1:0]         beat_addr,
  output logic [DATA_W-1:0]         beat_data,
  output logic [LEN_W-1:0]          beat_idx,
  output logic                      beat_first,
  output logic                      beat_last,
  output logic                      busy,
  output logic [LVL_W-1:0]          level
);
  localparam int unsigned STEP  = DATA_W / 8;
  localparam int unsigned AB    = $clog2(STEP);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << AB;

  typedef struct packed {
    logic                           write;
`ifdef AHB_BURST_WRAP_EN
    logic                           wrap;
`endif
    logic [ADDR_W-1:0]              addr;
    logic [LEN_W-1:0]               len;
    logic [MAX_LEN-1:0][DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                         state_q, state_d;
  entry_t                         mem_q [DEPTH];
  entry_t                         in_entry, src;
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]               count_q;
  logic                           push, pop, load, fifo_wr, beat_hs;
  logic                           cur_write_q;
  logic [ADDR_W-1:0]              lin_q;
  logic [LEN_W-1:0]               len_q, idx_q;
  logic [MAX_LEN-1:0][DATA_W-1:0] data_q;

`ifndef AHB_BURST_WRAP_EN
  logic unused_wrap;
  assign unused_wrap = req_wrap;
`endif

  // Clamp length and align address once, on the way in.
  always_comb begin
    in_entry       = '0;
    in_entry.write = req_write;
    in_entry.addr  = req_addr & ALIGN_MASK;
    in_entry.data  = req_data;
    if (req_len == '0)                     in_entry.len = LEN_W'(1);
    else if (req_len > LEN_W'(MAX_LEN))    in_entry.len = LEN_W'(MAX_LEN);
    else                                   in_entry.len = req_len;
`ifdef AHB_BURST_WRAP_EN
    in_entry.wrap  = req_wrap;
`endif
  end

  assign req_ready  = !rst && (count_q < LVL_W'(DEPTH));
  assign push       = req_valid && req_ready;
  assign beat_valid = (state_q == StBurst);
  assign beat_hs    = beat_valid && beat_ready;
  assign beat_first = beat_valid && (idx_q == '0);
  assign beat_last  = beat_valid && (idx_q == len_q - LEN_W'(1));
  assign busy       = beat_valid || (count_q != '0);
  assign level      = count_q;
  assign beat_write = cur_write_q;
  assign beat_idx   = idx_q;

  // An empty FIFO bypasses the incoming request straight into the sequencer.
  assign src     = (count_q != '0) ? mem_q[rd_ptr_q] : in_entry;
  assign pop     = load && (count_q != '0);
  assign fifo_wr = push && !(load && (count_q == '0));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) || push) begin
          load    = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (beat_hs && beat_last) begin
          if ((count_q != '0) || push) load = 1'b1;
          else                         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      count_q <= count_q + LVL_W'(fifo_wr) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_write_q <= 1'b0;
      lin_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
    end else if (load) begin
      cur_write_q <= src.write;
      lin_q       <= src.addr;
      len_q       <= src.len;
      idx_q       <= '0;
      data_q      <= src.write ? src.data : '0;
    end else if (beat_hs && !beat_last) begin
      idx_q <= idx_q + LEN_W'(1);
      lin_q <= lin_q + ADDR_W'(STEP);
    end
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == LEN_W'(i)) beat_data = data_q[i];
    end
  end

`ifdef AHB_BURST_WRAP_EN
  logic              wrap_q, src_wrap;
  logic [ADDR_W-1:0] mask_q, base_q, src_mask;

  // Only power-of-2 lengths above 1 wrap; everything else degenerates to INCR.
  always_comb begin
    src_mask = ADDR_W'(src.len) * ADDR_W'(STEP) - ADDR_W'(1);
    src_wrap = src.wrap && (src.len > LEN_W'(1)) &&
               ((src.len & (src.len - LEN_W'(1))) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      mask_q <= '0;
      base_q <= '0;
    end else if (load) begin
      wrap_q <= src_wrap;
      mask_q <= src_mask;
      base_q <= src.addr & ~src_mask;
    end
  end

  assign beat_addr = wrap_q ? (base_q | (lin_q & mask_q)) : lin_q;
`else
  assign beat_addr = lin_q;
`endif

endmodule

// File: tb/tb_ahb_req_burst_seq.sv
// Directed self-checking bench for ahb_req_burst_seq (default parameters).
module tb_ahb_req_burst_seq;
  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_wrap;
  logic [31:0]  req_addr;
  logic [3:0]   req_len;
  logic [255:0] req_data;
  logic         beat_valid;
  logic         beat_ready;
  logic         beat_write;
  logic [31:0]  beat_addr;
  logic [31:0]  beat_data;
  logic [3:0]   beat_idx;
  logic         beat_first;
  logic         beat_last;
  logic         busy;
  logic [2:0]   level;

  int checks = 0;
  int errors = 0;

  ahb_req_burst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_wrap   (req_wrap),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_data   (req_data),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_write (beat_write),
    .beat_addr  (beat_addr),
    .beat_data  (beat_data),
    .beat_idx   (beat_idx),
    .beat_first (beat_first),
    .beat_last  (beat_last),
    .busy       (busy),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] mk_data(input logic [31:0] base);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  // Offers one request for one clock; caller guarantees req_ready is high.
  task automatic push(input logic wr, input logic wp, input logic [31:0] a,
                      input logic [3:0] l, input logic [255:0] d);
    req_write = wr; req_wrap = wp; req_addr = a; req_len = l; req_data = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready[%0d] got %b exp 0", c, req_ready); end
      checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL rst_valid[%0d] got %b exp 0", c, beat_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level[%0d] got %0d exp 0", c, level); end
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy got %b exp 0", busy); end
  endtask

  task automatic test_incr_write();
    logic [31:0] ea [4];
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    beat_ready = 1'b1;
    push(1'b1, 1'b0, 32'h100, 4'd4, mk_data(32'hA0));
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_valid !== 1'b1) begin errors++; $display("FAIL incr_valid[%0d] got %b exp 1", i, beat_valid); end
      checks++; if (beat_addr !== ea[i]) begin errors++; $display("FAIL incr_addr[%0d] got %h exp %h", i, beat_addr, ea[i]); end
      checks++; if (beat_data !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL incr_data[%0d] got %h exp %h", i, beat_data, 32'hA0 + 32'(i)); end
      checks++; if (beat_idx !== 4'(i)) begin errors++; $display("FAIL incr_idx[%0d] got %0d exp %0d", i, beat_idx, i); end
      checks++; if (beat_first !== (i == 0)) begin errors++; $display("FAIL incr_first[%0d] got %b exp %b", i, beat_first, i == 0); end
      checks++; if (beat_last !== (i == 3)) begin errors++; $display("FAIL incr_last[%0d] got %b exp %b", i, beat_last, i == 3); end
      checks++; if (beat_write !== 1'b1) begin errors++; $display("FAIL incr_write[%0d] got %b exp 1", i, beat_write); end
      @(negedge clk);
    end
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL incr_end_valid got %b exp 0", beat_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL incr_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
`ifdef AHB_BURST_WRAP_EN
    ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
`else
    ea = '{32'h38, 32'h3C, 32'h40, 32'h44};
`endif
    beat_ready = 1'b1;
    push(1'b0, 1'b1, 32'h38, 4'd4, mk_data(32'hDEAD0000));
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, beat_addr, ea[i]); end
      checks++; if (beat_data !== 32'h0) begin errors++; $display("FAIL wrap_rdata[%0d] got %h exp 0", i, beat_data); end
      checks++; if (beat_write !== 1'b0) begin errors++; $display("FAIL wrap_write[%0d] got %b exp 0", i, beat_write); end
      @(negedge clk);
    end
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid got %b exp 0", beat_valid); end
  endtask

  task automatic test_incr_top();
    logic [31:0] ea [4];
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    beat_ready = 1'b1;
    push(1'b1, 1'b0, 32'hFFFF_FFF8, 4'd4, mk_data(32'hC0));
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr !== ea[i]) begin errors++; $display("FAIL top_addr[%0d] got %h exp %h", i, beat_addr, ea[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_len_clamp();
    beat_ready = 1'b1;
    push(1'b1, 1'b0, 32'h503, 4'd0, mk_data(32'hE0));
    checks++; if (beat_addr !== 32'h500) begin errors++; $display("FAIL len0_addr got %h exp 00000500", beat_addr); end
    checks++; if (beat_data !== 32'hE0) begin errors++; $display("FAIL len0_data got %h exp 000000e0", beat_data); end
    checks++; if ({beat_first, beat_last} !== 2'b11) begin errors++; $display("FAIL len0_flags got %b exp 11", {beat_first, beat_last}); end
    @(negedge clk);
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL len0_end got %b exp 0", beat_valid); end
    push(1'b1, 1'b0, 32'h600, 4'd15, mk_data(32'hF0));
    for (int i = 0; i < 8; i++) begin
      checks++; if (beat_valid !== 1'b1 || beat_idx !== 4'(i)) begin errors++; $display("FAIL clamp_idx[%0d] got v=%b idx=%0d exp v=1 idx=%0d", i, beat_valid, beat_idx, i); end
      checks++; if (beat_last !== (i == 7)) begin errors++; $display("FAIL clamp_last[%0d] got %b exp %b", i, beat_last, i == 7); end
      @(negedge clk);
    end
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL clamp_end got %b exp 0", beat_valid); end
  endtask

  task automatic test_backpressure();
    beat_ready = 1'b0;
    push(1'b1, 1'b0, 32'h200, 4'd2, mk_data(32'hB0));
    for (int c = 0; c < 5; c++) begin
      checks++; if (beat_valid !== 1'b1 || beat_addr !== 32'h200 || beat_data !== 32'hB0 || beat_idx !== 4'd0 || beat_first !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b a=%h d=%h i=%0d f=%b exp v=1 a=00000200 d=000000b0 i=0 f=1", c, beat_valid, beat_addr, beat_data, beat_idx, beat_first);
      end
      @(negedge clk);
    end
    beat_ready = 1'b1;
    checks++; if (beat_addr !== 32'h200) begin errors++; $display("FAIL bp_beat0 got %h exp 00000200", beat_addr); end
    @(negedge clk);
    checks++; if (beat_valid !== 1'b1 || beat_addr !== 32'h204 || beat_data !== 32'hB1 || beat_last !== 1'b1) begin
      errors++; $display("FAIL bp_beat1 got v=%b a=%h d=%h l=%b exp v=1 a=00000204 d=000000b1 l=1", beat_valid, beat_addr, beat_data, beat_last);
    end
    @(negedge clk);
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %b exp 0", beat_valid); end
  endtask

  task automatic test_full_fifo();
    logic [31:0] ea, ed;
    beat_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      push(1'b1, 1'b0, 32'h1000 * 32'(r + 1), 4'd8, mk_data(32'h100 * 32'(r)));
      checks++; if (level !== 3'(r)) begin errors++; $display("FAIL full_level[%0d] got %0d exp %0d", r, level, r); end
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req_ready); end
    req_write = 1'b1; req_addr = 32'h6000; req_len = 4'd8; req_data = mk_data(32'h600);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_refuse got %0d exp 4", level); end
    beat_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) begin
        ea = 32'h1000 * 32'(r + 1) + 32'(4 * i);
        ed = 32'h100 * 32'(r) + 32'(i);
        checks++; if (beat_valid !== 1'b1 || beat_addr !== ea || beat_data !== ed) begin
          errors++; $display("FAIL drain[%0d][%0d] got v=%b a=%h d=%h exp v=1 a=%h d=%h", r, i, beat_valid, beat_addr, beat_data, ea, ed);
        end
        if (i == 0) begin
          checks++; if (level !== 3'(4 - r)) begin errors++; $display("FAIL drain_level[%0d] got %0d exp %0d", r, level, 4 - r); end
        end
        @(negedge clk);
      end
    end
    checks++; if (beat_valid !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL drain_end got v=%b b=%b l=%0d exp v=0 b=0 l=0", beat_valid, busy, level);
    end
  endtask

  task automatic test_reset_mid();
    beat_ready = 1'b0;
    push(1'b1, 1'b0, 32'h300, 4'd8, mk_data(32'h30));
    push(1'b1, 1'b0, 32'h380, 4'd2, mk_data(32'h38));
    beat_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (beat_idx !== 4'd2 || beat_addr !== 32'h308) begin errors++; $display("FAIL mid_pre got i=%0d a=%h exp i=2 a=00000308", beat_idx, beat_addr); end
    rst = 1'b1;
    #1;
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", beat_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || busy !== 1'b0 || beat_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rel got l=%0d b=%b v=%b exp l=0 b=0 v=0", level, busy, beat_valid);
    end
    push(1'b1, 1'b0, 32'h400, 4'd3, mk_data(32'h40));
    for (int i = 0; i < 3; i++) begin
      checks++; if (beat_valid !== 1'b1 || beat_idx !== 4'(i) || beat_addr !== 32'h400 + 32'(4 * i)) begin
        errors++; $display("FAIL mid_next[%0d] got v=%b i=%0d a=%h exp v=1 i=%0d a=%h", i, beat_valid, beat_idx, beat_addr, i, 32'h400 + 32'(4 * i));
      end
      @(negedge clk);
    end
    checks++; if (beat_valid !== 1'b0) begin errors++; $display("FAIL mid_end got %b exp 0", beat_valid); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_wrap = 1'b0;
    req_addr = '0; req_len = 4'd1; req_data = '0; beat_ready = 1'b0;
    test_reset();
    test_incr_write();
    test_wrap();
    test_incr_top();
    test_len_clamp();
    test_backpressure();
    test_full_fifo();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
